bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 16-bit tri-state data bus between N drivers.
//  Produces registered one-hot enables; each enable feeds the S input of one driver's tri-state buffer.
//  Guarantees at most one enable is high in any cycle, bounds bus tenure and optionally inserts a turnaround cycle.
//  Sits beside the bus in the processor datapath; the bus drivers are register file, ALU and memory read ports.
// PARAMETERS
//  N        4  number of requesters, 2..16
//  MAX_HOLD 8  max consecutive grant cycles per tenure; 0 = unlimited
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         synchronous, active-high reset
//  req         in   N         request vector, level-sensitive, bit i = requester i
//  grant       out  N         one-hot or zero bus-drive enable, registered
//  owner_valid out  1         high when any grant bit is high
//  owner_id    out  clog2(N)  index of the granted requester; 0 when owner_valid=0
// BEHAVIOUR
//  - Single clock domain; reset is synchronous and active-high; all outputs registered.
//  - Reset values:
//    - grant=0, owner_valid=0, owner_id=0.
//    - Round-robin pointer ptr=0, hold_cnt=0, state=IDLE.
//    - rst high on any edge forces these values, including mid-tenure; the bus is released on that edge.
//  - FSM states: IDLE, GRANT, TURN.
//  - IDLE, any req bit set:
//    - Pick the first set bit searching ptr, ptr+1 .. wrapping mod N.
//    - Next edge: grant=onehot(pick), state=GRANT, hold_cnt=1.
//    - Latency from req to grant is 1 cycle.
//  - IDLE, req=0: stay in IDLE with grant=0.
//  - GRANT, release condition at an edge:
//    - req[owner]=0, or
//    - MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
//  - GRANT with no release: hold grant; hold_cnt saturates at MAX_HOLD.
//  - Grant stays high in the cycle the owner drops req; it falls on the following edge.
//  - On release: ptr = (owner+1) mod N, so the old owner has lowest priority next.
//  - Requests from non-owners during GRANT are ignored until release; there is no pre-emption.
//  - A forced release with only the owner still requesting re-grants the same owner (hold_cnt=1).
//  - req bits may change at any time; no handshake acknowledge beyond grant.
//  - Invariant: $onehot0(grant) every cycle; owner_id and owner_valid are consistent with grant.
// CONFIGURATION
//  Macro BUS_ARB_TURNAROUND_EN.
//  - Defined:
//    - Release edge sets grant=0 and state=TURN for exactly 1 cycle.
//    - TURN then arbitrates like IDLE using the updated ptr.
//    - Ownership change therefore costs 2 edges; two drivers are never enabled on adjacent cycles.
//  - Undefined:
//    - TURN state is removed.
//    - The release edge arbitrates directly: grant switches old->new one-hot in one edge.
//    - If no req is pending, grant=0 and state=IDLE.
// STRUCTURE
//  - Package bus_arb_pkg:
//    - State encoding: IDLE=2'b00, GRANT=2'b01, TURN=2'b10.
//    - Constants BUS_W=16, ID_W=clog2(N) helper, and a onehot() helper function.
//  - One sub-module, rr_pick: combinational rotate-priority encoder.
//    - Inputs: req and ptr. Outputs: pick_id and pick_valid.
//    - Instantiated once.
//  - Top holds FSM, ptr and hold_cnt.
// TESTING
//  1. rst=1 for 2 cycles with req=4'b1111 -> grant=0, owner_valid=0 throughout; after rst drops, grant=4'b0001 on the next edge.
//  2. req=4'b0100 held 3 cycles then 0 -> grant=4'b0100 for 3 cycles starting 1 cycle after req, then 0; ptr=3.
//  3. req=4'b1111 held continuously, MAX_HOLD=8 -> order 0,1,2,3,0; each tenure exactly 8 cycles, plus 1 zero cycle between tenures with BUS_ARB_TURNAROUND_EN.
//  4. Owner 1 granted; req[3] rises mid-tenure -> grant unchanged until req[1] drops; then grant=4'b1000 on the next edge, or 2 edges with BUS_ARB_TURNAROUND_EN.
//  5. Only req[2] held 20 cycles, MAX_HOLD=8 -> forced release at cycle 8, re-granted to 2; with TURN, 1-cycle gap every 8 cycles.
//  6. rst pulsed for 1 cycle mid-tenure of owner 2 -> grant=0 the next cycle; then grant goes to requester 0 if req[0]=1 (ptr reset).
//  All scenarios: assert $onehot0(grant) every cycle and owner_id==index(grant).

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: state encodings, width helper, one-hot helper.
// Optional turnaround cycle is enabled by defining BUS_ARB_TURNAROUND_EN.
package bus_arb_pkg;

    localparam int unsigned BUS_W = 16;
    localparam int unsigned MAX_N = 16;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GRANT = 2'b01;
    localparam logic [1:0] TURN  = 2'b10;

    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] id);
        logic [MAX_N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit at or after ptr, wrapping mod N.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] pick_id,
    output logic            pick_valid
);

    logic [ID_W-1:0] sel;

    always_comb begin
        pick_id    = '0;
        pick_valid = 1'b0;
        sel        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel = ID_W'((32'(ptr) + i) % N);
            if (!pick_valid && req[sel]) begin
                pick_valid = 1'b1;
                pick_id    = sel;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing registered one-hot tri-state enables for a shared bus.
// Define BUS_ARB_TURNAROUND_EN to insert one idle cycle between bus owners.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 owner_valid,
    output logic [id_w(N)-1:0]   owner_id
);

    localparam int unsigned     ID_W     = id_w(N);
    localparam int unsigned     HC_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);

    logic [1:0]      state, state_n;
    logic [ID_W-1:0] ptr, ptr_n, ptr_rel, arb_ptr;
    logic [HC_W-1:0] hold_cnt, hold_n;
    logic [N-1:0]    grant_n, pick_oh;
    logic            owner_valid_n;
    logic [ID_W-1:0] owner_id_n;
    logic [ID_W-1:0] pick_id;
    logic            pick_valid;
    logic            rel, do_take, do_drop;

    assign rel     = (state == GRANT) &&
                     (!req[owner_id] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM)));
    assign ptr_rel = (owner_id == ID_W'(N - 1)) ? '0 : owner_id + ID_W'(1);
    // On a release edge the picker must already see the rotated pointer.
    assign arb_ptr = (state == GRANT) ? ptr_rel : ptr;
    assign pick_oh = N'(onehot(4'(pick_id)));

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req        (req),
        .ptr        (arb_ptr),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        hold_n        = hold_cnt;
        grant_n       = grant;
        owner_valid_n = owner_valid;
        owner_id_n    = owner_id;
        do_take       = 1'b0;
        do_drop       = 1'b0;
        case (state)
            GRANT: begin
                if (rel) begin
                    ptr_n = ptr_rel;
`ifdef BUS_ARB_TURNAROUND_EN
                    state_n = TURN;
                    do_drop = 1'b1;
`else
                    state_n = IDLE;
                    do_take = pick_valid;
                    do_drop = !pick_valid;
`endif
                end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) begin
                    hold_n = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                do_take = pick_valid;
                do_drop = !pick_valid;
            end
        endcase
        if (do_take) begin
            state_n       = GRANT;
            grant_n       = pick_oh;
            owner_valid_n = 1'b1;
            owner_id_n    = pick_id;
            hold_n        = HC_W'(1);
        end else if (do_drop) begin
            grant_n       = '0;
            owner_valid_n = 1'b0;
            owner_id_n    = '0;
            hold_n        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_n;
            grant       <= grant_n;
            owner_valid <= owner_valid_n;
            owner_id    <= owner_id_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (N=4, MAX_HOLD=8); expectations follow BUS_ARB_TURNAROUND_EN.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       owner_valid;
    logic [1:0] owner_id;

    logic [3:0] exp_q[$];
    int         checks = 0;
    int         passed = 0;
    int         step   = 0;

    bus_arbiter #(
        .N        (4),
        .MAX_HOLD (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .owner_valid (owner_valid),
        .owner_id    (owner_id)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
    endtask

    // Drive one cycle of stimulus and queue the grant expected after the next edge.
    task automatic vec(input logic r, input logic [3:0] q, input logic [3:0] e);
        @(negedge clk);
        rst = r;
        req = q;
        exp_q.push_back(e);
    endtask

    task automatic vecs(input int n, input logic [3:0] q, input logic [3:0] e);
        for (int i = 0; i < n; i++) vec(1'b0, q, e);
    endtask

    // Extra idle cycle present only when the turnaround feature is built in.
    task automatic gap(input logic [3:0] q);
`ifdef BUS_ARB_TURNAROUND_EN
        vec(1'b0, q, 4'b0000);
`else
        if (q === 4'bxxxx) vec(1'b0, q, 4'b0000);
`endif
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                step++;
                check("grant", int'(grant), int'(e));
                check("owner_valid", int'(owner_valid), int'(|e));
                check("owner_id", int'(owner_id), idx_of(e));
                check("onehot0", int'($onehot0(grant)), 1);
            end
        end
    end

    initial begin
        // 1: reset with all requesting, then first grant goes to 0
        vec(1'b1, 4'b1111, 4'b0000);
        vec(1'b1, 4'b1111, 4'b0000);
        vec(1'b0, 4'b1111, 4'b0001);
        vec(1'b0, 4'b0000, 4'b0000);
        vec(1'b1, 4'b0000, 4'b0000);
        // 2: single requester for 3 cycles; ptr then 3, seen by next pick
        vecs(3, 4'b0100, 4'b0100);
        vec(1'b0, 4'b0000, 4'b0000);
        vec(1'b0, 4'b1111, 4'b1000);
        vec(1'b0, 4'b0000, 4'b0000);
        // 3: all requesting, 8-cycle tenures in order 0,1,2,3,0
        vecs(8, 4'b1111, 4'b0001); gap(4'b1111);
        vecs(8, 4'b1111, 4'b0010); gap(4'b1111);
        vecs(8, 4'b1111, 4'b0100); gap(4'b1111);
        vecs(8, 4'b1111, 4'b1000); gap(4'b1111);
        vecs(8, 4'b1111, 4'b0001);
        vec(1'b0, 4'b0000, 4'b0000);
        // 4: no pre-emption by req[3] while owner 1 holds
        vec(1'b0, 4'b0010, 4'b0010);
        vecs(3, 4'b1010, 4'b0010);
        gap(4'b1000);
        vecs(2, 4'b1000, 4'b1000);
        vec(1'b0, 4'b0000, 4'b0000);
        // 5: lone requester forced off at MAX_HOLD and re-granted
        vecs(8, 4'b0100, 4'b0100); gap(4'b0100);
        vecs(8, 4'b0100, 4'b0100); gap(4'b0100);
        vecs(4, 4'b0100, 4'b0100);
        vec(1'b0, 4'b0000, 4'b0000);
        // 6: reset mid-tenure of owner 2 clears ptr
        vec(1'b0, 4'b0100, 4'b0100);
        vecs(2, 4'b0101, 4'b0100);
        vec(1'b1, 4'b0101, 4'b0000);
        vec(1'b0, 4'b0101, 4'b0001);
        vec(1'b0, 4'b0000, 4'b0000);
        vec(1'b0, 4'b0101, 4'b0100);
        vec(1'b0, 4'b0000, 4'b0000);

        @(negedge clk);
        @(posedge clk);
        #2;
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
